// File: rtl/vga_vtiming.sv
// vga_vtiming: vertical timing, pixel coordinates and hsync lock watchdog for the ToVga path.
module vga_vtiming #(
    parameter int V_SYNCPULSE = 2,
    parameter int V_BPORCH    = 33,
    parameter int V_DISPLAY   = 480,
    parameter int V_FPORCH    = 10,
    parameter int V_SYNC      = 525,
    parameter int H_DISPLAY   = 640,
    parameter int WD_TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       hdisp_n,
    output logic       vsync,
    output logic       vdisp_n,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       locked
);
    localparam int WD_W = $clog2(WD_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_TIMEOUT);
    localparam logic [9:0] V_LAST = 10'(V_SYNC - 1);
    localparam logic [9:0] V_SP   = 10'(V_SYNCPULSE);
    localparam logic [9:0] V_A0   = 10'(V_SYNCPULSE + V_BPORCH);
    localparam logic [9:0] V_A1   = 10'(V_SYNCPULSE + V_BPORCH + V_DISPLAY);
    localparam logic [9:0] H_LAST = 10'(H_DISPLAY - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t state, state_nx;

    logic            hs_prev, armed, line_tick, timeout, wrap, act_nx, pv_nx;
    logic [9:0]      v_cnt, v_nx, h_cnt;
    logic [WD_W-1:0] wd;

    // armed blocks a tick from an hsync level that was already high when reset released
    assign line_tick = hsync_in & ~hs_prev & armed;
    assign timeout   = (state == LOCKED) & ~line_tick & (wd == WD_MAX);
    assign wrap      = (state == LOCKED) & line_tick & (v_cnt == V_LAST);
    assign pv_nx     = locked & ~hdisp_n & ~vdisp_n;

    always_comb begin
        state_nx = state;
        v_nx     = '0;
        if (state == SEARCH)
            state_nx = line_tick ? LOCKED : SEARCH;
        else
            state_nx = timeout ? SEARCH : LOCKED;
        if (state == LOCKED && v_cnt != V_LAST)
            v_nx = v_cnt + 10'd1;
        act_nx = (v_nx >= V_A0) && (v_nx < V_A1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            hs_prev     <= 1'b0;
            armed       <= 1'b0;
            v_cnt       <= '0;
            wd          <= '0;
            h_cnt       <= '0;
            vsync       <= 1'b0;
            vdisp_n     <= 1'b1;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nx;
            hs_prev     <= hsync_in;
            armed       <= armed | ~hsync_in;
            frame_start <= 1'b0;
            if ((state == SEARCH && !line_tick) || timeout) begin
                v_cnt     <= '0;
                wd        <= '0;
                h_cnt     <= '0;
                vsync     <= 1'b0;
                vdisp_n   <= 1'b1;
                pix_valid <= 1'b0;
                pix_x     <= '0;
                pix_y     <= '0;
                locked    <= 1'b0;
            end else begin
                locked    <= 1'b1;
                wd        <= line_tick ? '0 : wd + 1'b1;
                h_cnt     <= line_tick ? '0 : (!hdisp_n && h_cnt != H_LAST) ? h_cnt + 10'd1 : h_cnt;
                pix_valid <= pv_nx;
                pix_x     <= pv_nx ? h_cnt : '0;
                if (line_tick) begin
                    v_cnt       <= v_nx;
                    vsync       <= v_nx < V_SP;
                    vdisp_n     <= ~act_nx;
                    pix_y       <= act_nx ? 9'(v_nx - V_A0) : '0;
                    frame_start <= (state == SEARCH) | wrap;
                    frame_cnt   <= frame_cnt + 8'(wrap);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_vtiming.sv
// tb_vga_vtiming: directed vector table plus line-level sequences for vga_vtiming.
module tb_vga_vtiming;
    logic       clk = 0, rst = 1, hsync_in = 1, hdisp_n = 1;
    logic       vsync, vdisp_n, pix_valid, frame_start, locked;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [7:0] frame_cnt;

    int nchk = 0, nerr = 0, ncyc = 0, tick_cyc = 0;
    int o_vs, o_vd, o_py, o_lk, o_cnt, o_fs, o_fs_c, o_first_c, o_first_x, o_pen_x, o_last_x, o_xbad, o_wrap;

    typedef struct {
        logic hs, hd, vs, vd, lk, fs, pv;
    } vec_t;
    vec_t tv[9];

    vga_vtiming dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .hdisp_n(hdisp_n),
        .vsync(vsync), .vdisp_n(vdisp_n), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .frame_start(frame_start), .frame_cnt(frame_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic hs, input logic hd);
        hsync_in = hs;
        hdisp_n  = hd;
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic chk_reset_outputs(input string tag, input int fc);
        chk({tag, " vsync"}, vsync, 0);
        chk({tag, " vdisp_n"}, vdisp_n, 1);
        chk({tag, " pix_valid"}, pix_valid, 0);
        chk({tag, " pix_x"}, pix_x, 0);
        chk({tag, " pix_y"}, pix_y, 0);
        chk({tag, " frame_start"}, frame_start, 0);
        chk({tag, " frame_cnt"}, frame_cnt, fc);
        chk({tag, " locked"}, locked, 0);
    endtask

    task automatic run_line(input int len, input int hs_len, input int hd0, input int hdn);
        o_cnt = 0; o_fs = 0; o_fs_c = -1; o_first_c = -1; o_first_x = -1;
        o_pen_x = -1; o_last_x = -1; o_xbad = 0; o_wrap = 0;
        for (int c = 0; c < len; c++) begin
            cyc(c < hs_len, !(c >= hd0 && c < hd0 + hdn));
            if (c == 0) tick_cyc = ncyc;
            if (pix_valid) begin
                if (o_cnt == 0) begin
                    o_first_c = c;
                    o_first_x = pix_x;
                end else if (int'(pix_x) < o_last_x) o_wrap++;
                o_pen_x  = o_last_x;
                o_last_x = pix_x;
                o_cnt++;
            end else if (pix_x != 0) o_xbad++;
            if (frame_start) begin
                o_fs++;
                o_fs_c = c;
            end
            if (c == len / 2) begin
                o_vs = vsync; o_vd = vdisp_n; o_py = pix_y; o_lk = locked;
            end
        end
    endtask

    task automatic check_line(input int l, input int hdn);
        bit act;
        act = (l >= 35) && (l < 515);
        chk($sformatf("vsync L%0d", l), o_vs, int'(l < 2));
        chk($sformatf("vdisp_n L%0d", l), o_vd, int'(!act));
        chk($sformatf("pix_y L%0d", l), o_py, act ? l - 35 : 0);
        chk($sformatf("pix_count L%0d", l), o_cnt, act ? hdn : 0);
        chk($sformatf("frame_start L%0d", l), o_fs, int'(l == 0));
        chk($sformatf("locked L%0d", l), o_lk, 1);
        chk($sformatf("pix_x_idle L%0d", l), o_xbad, 0);
        if (l == 0) chk("frame_start cycle", o_fs_c, 0);
    endtask

    task automatic short_line(input int l);
        run_line(40, 4, 10, 20);
        check_line(l, 20);
    endtask

    initial begin
        int drop;
        tv[0] = '{0, 1, 0, 1, 0, 0, 0};
        tv[1] = '{1, 1, 1, 1, 1, 1, 0};
        tv[2] = '{1, 0, 1, 1, 1, 0, 0};
        tv[3] = '{0, 0, 1, 1, 1, 0, 0};
        tv[4] = '{1, 1, 1, 1, 1, 0, 0};
        tv[5] = '{0, 1, 1, 1, 1, 0, 0};
        tv[6] = '{1, 1, 0, 1, 1, 0, 0};
        tv[7] = '{1, 1, 0, 1, 1, 0, 0};
        tv[8] = '{0, 1, 0, 1, 1, 0, 0};

        // reset with hsync already high, then hold it high: no tick allowed
        repeat (3) cyc(1, 1);
        chk_reset_outputs("reset", 0);
        rst = 0;
        repeat (50) cyc(1, 1);
        chk_reset_outputs("held_high_after_reset", 0);

        for (int i = 0; i < 9; i++) begin
            cyc(tv[i].hs, tv[i].hd);
            chk($sformatf("tv%0d vsync", i), vsync, tv[i].vs);
            chk($sformatf("tv%0d vdisp_n", i), vdisp_n, tv[i].vd);
            chk($sformatf("tv%0d locked", i), locked, tv[i].lk);
            chk($sformatf("tv%0d frame_start", i), frame_start, tv[i].fs);
            chk($sformatf("tv%0d pix_valid", i), pix_valid, tv[i].pv);
        end

        for (int l = 3; l < 525; l++) short_line(l);
        short_line(0);
        chk("frame_cnt after wrap", frame_cnt, 1);
        for (int l = 1; l < 35; l++) short_line(l);

        for (int l = 35; l < 37; l++) begin
            run_line(800, 96, 144, 640);
            check_line(l, 640);
            chk("first valid cycle", o_first_c, 144);
            chk("first pix_x", o_first_x, 0);
            chk("penultimate pix_x", o_pen_x, 638);
            chk("last pix_x", o_last_x, 639);
        end

        run_line(900, 4, 100, 700);
        check_line(37, 700);
        chk("overlong last pix_x", o_last_x, 639);
        chk("overlong penultimate pix_x", o_pen_x, 639);
        chk("overlong wrap", o_wrap, 0);

        run_line(1000, 990, 0, 0);
        check_line(38, 0);
        short_line(39);

        drop = -1;
        for (int k = 0; k < 1100; k++) begin
            cyc(0, 1);
            if (drop < 0 && !locked) begin
                drop = ncyc - tick_cyc;
                chk_reset_outputs("watchdog", 1);
            end
        end
        chk("watchdog drop delay", drop, 1024);
        short_line(0);
        chk("frame_cnt after relock", frame_cnt, 1);

        for (int l = 1; l < 300; l++) short_line(l);
        for (int c = 0; c < 20; c++) cyc(c < 4, !(c >= 10 && c < 30));
        chk("line300 pix_y", pix_y, 265);
        chk("line300 pix_valid", pix_valid, 1);
        chk("line300 pix_x", pix_x, 9);
        rst = 1;
        cyc(0, 1);
        rst = 0;
        chk_reset_outputs("midframe_reset", 0);
        cyc(0, 1);
        chk("search after reset", locked, 0);
        short_line(0);
        chk("frame_cnt after reset relock", frame_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
